// File: rtl/lock_sequencer.sv
// lock_sequencer: 4-digit combination-lock controller with code reprogramming and fail counting.
// Optional timed lockout after MAX_FAILS consecutive wrong codes: define LOCK_SEQ_LOCKOUT_EN.
module lock_sequencer #(
  parameter logic [15:0] DEFAULT_CODE  = 16'h1234,
  parameter int          MAX_FAILS     = 3,
  parameter int          TICKS_PER_SEC = 5000000,
  parameter int          LOCKOUT_SECS  = 10
) (
  input  logic       clk5,
  input  logic       resetN,
  input  logic       digitValid,
  input  logic [3:0] digit,
  input  logic       clearReq,
  input  logic       progReq,
  input  logic       timeUp,
  output logic [2:0] whichState,
  output logic       unlock,
  output logic       error,
  output logic       progActive,
  output logic [2:0] failCount
);

  typedef enum logic [2:0] {
    IDLE         = 3'b000,
    GOT1         = 3'b001,
    GOT2         = 3'b010,
    GOT3         = 3'b011,
    PROGRAM      = 3'b100,
    CORRECT_CODE = 3'b101,
    WRONG_CODE   = 3'b110,
    LOCKOUT      = 3'b111
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] code_q, code_d;
  logic [15:0] entry_q, entry_d;
  logic [15:0] shadow_q, shadow_d;
  logic [2:0]  fail_q, fail_d;
  logic [1:0]  pidx_q, pidx_d;
  logic [15:0] full_entry_s;
  logic        code_ok_s;
  logic        unlock_q, error_q, prog_q;

  // A keypad value above 9 can never be part of a matching entry.
  function automatic logic bcd_ok(input logic [15:0] v);
    return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

`ifdef LOCK_SEQ_LOCKOUT_EN
  localparam int             LOCK_TICKS  = LOCKOUT_SECS * TICKS_PER_SEC;
  localparam int             LCW         = $clog2(LOCK_TICKS + 1);
  localparam logic [LCW-1:0] LOCK_LAST   = LCW'(LOCK_TICKS - 1);
  localparam logic [2:0]     MAX_FAILS_C = 3'(MAX_FAILS);
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ^{MAX_FAILS, TICKS_PER_SEC, LOCKOUT_SECS};
`endif

  assign full_entry_s = {entry_q[15:4], digit};
  assign code_ok_s    = (full_entry_s == code_q) && bcd_ok(full_entry_s);

  // Next-state, entry, programming and fail-count logic.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    entry_d  = entry_q;
    shadow_d = shadow_q;
    fail_d   = fail_q;
    pidx_d   = pidx_q;
`ifdef LOCK_SEQ_LOCKOUT_EN
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (digitValid) begin
          entry_d[15:12] = digit;
          state_d        = GOT1;
        end else begin
          state_d = IDLE;
        end
      end
      GOT1, GOT2: begin
        if (clearReq) begin
          entry_d = 16'h0000;
          state_d = IDLE;
        end else if (digitValid) begin
          if (state_q == GOT1) begin
            entry_d[11:8] = digit;
            state_d       = GOT2;
          end else begin
            entry_d[7:4] = digit;
            state_d      = GOT3;
          end
        end else begin
          state_d = state_q;
        end
      end
      GOT3: begin
        if (clearReq) begin
          entry_d = 16'h0000;
          state_d = IDLE;
        end else if (digitValid) begin
          entry_d[3:0] = digit;
          if (code_ok_s) begin
            state_d = CORRECT_CODE;
            fail_d  = 3'd0;
          end else begin
            state_d = WRONG_CODE;
            fail_d  = (fail_q == 3'd7) ? 3'd7 : fail_q + 3'd1;
          end
        end else begin
          state_d = GOT3;
        end
      end
      CORRECT_CODE: begin
        if (timeUp) begin
          state_d = IDLE;
        end else if (progReq) begin
          state_d = PROGRAM;
          pidx_d  = 2'd0;
        end else begin
          state_d = CORRECT_CODE;
        end
      end
      WRONG_CODE: begin
        if (timeUp) begin
`ifdef LOCK_SEQ_LOCKOUT_EN
          if (fail_q >= MAX_FAILS_C) begin
            state_d    = LOCKOUT;
            lock_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end else begin
          state_d = WRONG_CODE;
        end
      end
      PROGRAM: begin
        if (clearReq) begin
          state_d = IDLE;
          pidx_d  = 2'd0;
        end else if (digitValid) begin
          // Nibble base index is (3 - idx) * 4, i.e. first digit lands in [15:12].
          shadow_d[{~pidx_q, 2'b00} +: 4] = digit;
          if (pidx_q == 2'd3) begin
            code_d  = {shadow_q[15:4], digit};
            state_d = IDLE;
            pidx_d  = 2'd0;
          end else begin
            pidx_d = pidx_q + 2'd1;
          end
        end else begin
          state_d = PROGRAM;
        end
      end
      LOCKOUT: begin
`ifdef LOCK_SEQ_LOCKOUT_EN
        if (lock_cnt_q == LOCK_LAST) begin
          state_d = IDLE;
          fail_d  = 3'd0;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers plus outputs decoded from the next state so they leave flops directly.
  always_ff @(posedge clk5 or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      code_q   <= DEFAULT_CODE;
      entry_q  <= 16'h0000;
      shadow_q <= 16'h0000;
      fail_q   <= 3'd0;
      pidx_q   <= 2'd0;
      unlock_q <= 1'b0;
      error_q  <= 1'b0;
      prog_q   <= 1'b0;
`ifdef LOCK_SEQ_LOCKOUT_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      entry_q  <= entry_d;
      shadow_q <= shadow_d;
      fail_q   <= fail_d;
      pidx_q   <= pidx_d;
      unlock_q <= (state_d == CORRECT_CODE);
      error_q  <= (state_d == WRONG_CODE) || (state_d == LOCKOUT);
      prog_q   <= (state_d == PROGRAM);
`ifdef LOCK_SEQ_LOCKOUT_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign whichState = state_q;
  assign failCount  = fail_q;
  assign unlock     = unlock_q;
  assign error      = error_q;
  assign progActive = prog_q;

endmodule
